// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver for the host command path.
// The RX line is synchronised, oversampled OVS times per bit and
// majority-voted. Each byte is presented on omData with a READY_WIDTH-clock
// strobe. omData is written only on the clock where the strobe rises, so the
// downstream decoder can latch on the rising edge and advance on the falling
// edge.
module uart_byte_rx #(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned OVS         = 16,
    parameter int unsigned READY_WIDTH = 4
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iRx,
    output logic [7:0] omData,
    output logic       omData_Ready,
    output logic       oFrame_Err,
    output logic       oBusy
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int unsigned DIV    = CLK_HZ / (BAUD * OVS);
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TICK_W = $clog2(OVS);

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [TICK_W-1:0] T_LAST   = TICK_W'(OVS - 1);
    localparam logic [TICK_W-1:0] T_SMP0   = TICK_W'(OVS / 2 - 1);
    localparam logic [TICK_W-1:0] T_SMP1   = TICK_W'(OVS / 2);
    localparam logic [TICK_W-1:0] T_SMP2   = TICK_W'(OVS / 2 + 1);
    localparam logic [7:0]        RDY_LAST = 8'(READY_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t r_state;
    state_t w_next;

    // Synchroniser and edge detector
    logic r_sync1;
    logic r_sync2;
    logic r_rx_prev;
    logic w_rx;
    logic w_fall;

    // Bit timing
    logic [DIV_W-1:0]  r_div_cnt;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [TICK_W-1:0] r_brk_cnt;
    logic              w_tick;
    logic              w_bit_end;
    logic              w_chk_pt;
    logic              w_vote_pt;
    logic              w_brk_done;

    // Sampling and data path
    logic       r_smp0;
    logic       r_smp1;
    logic       w_vote;
    logic [2:0] r_bit_idx;
    logic [7:0] r_shift;

    // Output registers
    logic [7:0] r_data;
    logic       r_ready;
    logic [7:0] r_rdy_cnt;
    logic       r_ferr;

    // FSM-decoded strobes
    logic w_enter_start;
    logic w_active;
    logic w_shift_en;
    logic w_load;
    logic w_ferr;

    // ------------------------------------------------------------------
    // Shared combinational helpers
    // ------------------------------------------------------------------
    assign w_rx       = r_sync2;
    assign w_fall     = r_rx_prev & ~r_sync2;
    assign w_tick     = (r_div_cnt == DIV_LAST);
    assign w_bit_end  = w_tick && (r_tick_cnt == T_LAST);
    assign w_chk_pt   = w_tick && (r_tick_cnt == T_SMP1);
    assign w_vote_pt  = w_tick && (r_tick_cnt == T_SMP2);
    assign w_vote     = (r_smp0 & r_smp1) | (r_smp0 & w_rx) | (r_smp1 & w_rx);
    assign w_brk_done = (r_state == S_BREAK) && w_tick && w_rx && (r_brk_cnt == T_LAST);

    // Two-flop synchroniser plus history flop; preset high to match an idle line
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= iRx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; STOP returns to IDLE at the vote point so the next
    // start edge can be caught even with no idle gap between frames
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                if (w_chk_pt && w_rx) begin
                    w_next = S_IDLE;
                end else if (w_bit_end) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_vote_pt) begin
                    w_next = w_vote ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (w_brk_done) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Output decode from the current state
    always_comb begin
        w_enter_start = 1'b0;
        w_active      = 1'b0;
        w_shift_en    = 1'b0;
        w_load        = 1'b0;
        w_ferr        = 1'b0;
        oBusy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                w_enter_start = w_fall;
            end
            S_START: begin
                w_active = 1'b1;
            end
            S_DATA: begin
                w_active   = 1'b1;
                w_shift_en = w_vote_pt;
            end
            S_STOP: begin
                w_active = 1'b1;
                w_load   = w_vote_pt && w_vote;
                w_ferr   = w_vote_pt && !w_vote;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bit timing
    // ------------------------------------------------------------------

    // Oversample tick divider; restarted on the start edge so bit timing
    // is phase-aligned to the detected falling edge
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_div_cnt <= '0;
        end else if (w_enter_start || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Tick position within the current bit, 0..OVS-1
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_tick_cnt <= '0;
        end else if (w_enter_start) begin
            r_tick_cnt <= '0;
        end else if (w_active && w_tick) begin
            r_tick_cnt <= (r_tick_cnt == T_LAST) ? '0 : r_tick_cnt + 1'b1;
        end
    end

    // Run length of consecutive high ticks while in BREAK
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_brk_cnt <= '0;
        end else if (r_state != S_BREAK) begin
            r_brk_cnt <= '0;
        end else if (w_tick) begin
            r_brk_cnt <= w_rx ? r_brk_cnt + 1'b1 : '0;
        end
    end

    // ------------------------------------------------------------------
    // Sampling and deserialisation
    // ------------------------------------------------------------------

    // Hold the first two of the three mid-bit samples; the third is the live line
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_smp0 <= 1'b0;
            r_smp1 <= 1'b0;
        end else if (w_active && w_tick) begin
            if (r_tick_cnt == T_SMP0) begin
                r_smp0 <= w_rx;
            end
            if (r_tick_cnt == T_SMP1) begin
                r_smp1 <= w_rx;
            end
        end
    end

    // Bit index within the data field
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_bit_idx <= '0;
        end else if (w_enter_start) begin
            r_bit_idx <= '0;
        end else if ((r_state == S_DATA) && w_bit_end) begin
            r_bit_idx <= r_bit_idx + 1'b1;
        end
    end

    // LSB-first shift register fed by the voted bit
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_shift <= '0;
        end else if (w_shift_en) begin
            r_shift <= {w_vote, r_shift[7:1]};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    // Byte register and ready strobe; the width counter is independent of
    // the FSM and a new byte reloads it
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_data    <= '0;
            r_ready   <= 1'b0;
            r_rdy_cnt <= '0;
        end else if (w_load) begin
            r_data    <= r_shift;
            r_ready   <= 1'b1;
            r_rdy_cnt <= RDY_LAST;
        end else if (r_rdy_cnt != '0) begin
            r_rdy_cnt <= r_rdy_cnt - 8'd1;
        end else begin
            r_ready <= 1'b0;
        end
    end

    // One-clock framing error pulse on a bad stop bit
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_ferr <= 1'b0;
        end else begin
            r_ferr <= w_ferr;
        end
    end

    assign omData       = r_data;
    assign omData_Ready = r_ready;
    assign oFrame_Err   = r_ferr;

    // Configuration sanity: the strobe must end well before the next byte
    ap_cfg: assert property (@(posedge iClk) disable iff (iRst)
        (DIV >= 1) && (OVS >= 8) && ((OVS % 2) == 0) &&
        (READY_WIDTH >= 1) && (READY_WIDTH <= 255) &&
        (READY_WIDTH < DIV * OVS * 9))
        else $error("uart_byte_rx: illegal DIV/OVS/READY_WIDTH combination");

endmodule
